vbw_mul_seq: RTL and testbench

Iterative radix-2 shift-add multiplier with variable lane width, built around the variable bit-width CLA datapath.
- One 64-bit operand pair is split by `control` into 1x64, 2x32, 4x16 or 8x8 independent lanes.
- Each lane produces its product modulo 2^lane_width. This is the low half of the product, truncated.
- Every cycle, one partial product per lane is accumulated through a lane-segmented add: carries never cross a lane boundary.
- It sits upstream of the vector writeback stage and uses a valid/ready handshake on both sides.

---
 rtl/vbw_mul_seq.sv | 139 +++++++++++++
 tb/tb_vbw_mul_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vbw_mul_seq.sv
// Iterative radix-2 shift-add multiplier with variable lane width.
// A 64-bit operand pair is split into 1x64, 2x32, 4x16 or 8x8 lanes. Each lane produces its
// product modulo 2^lane_width, one partial product per cycle, through a lane-segmented add.
// Optional build macro VBW_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits
// are all zero instead of always running lane-width iterations.
module vbw_mul_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             busy
);

  localparam int unsigned NumBytes = WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mplier_q, acc_q;
  logic [1:0]           mode_q;
  logic [5:0]           cnt_q;

  logic [NumBytes-1:0]  byte_start;  // byte j is the lowest byte of a lane
  logic [NumBytes-1:0]  byte_en;     // lane of byte j adds the multiplicand this cycle
  logic [5:0]           last_cnt;
  logic [WIDTH-1:0]     start_bits, msb_bits;
  logic [WIDTH-1:0]     acc_sum, mcand_shl, mplier_shr;
  logic                 accept, run_last;

  assign accept = (state_q == StIdle) && in_valid;

  // Lane boundaries and iteration limit for the latched mode
  always_comb begin
    byte_start = '0;
    last_cnt   = '0;
    unique case (mode_q)
      2'b00: begin byte_start = 8'b0000_0001; last_cnt = 6'd63; end
      2'b01: begin byte_start = 8'b0001_0001; last_cnt = 6'd31; end
      2'b10: begin byte_start = 8'b0101_0101; last_cnt = 6'd15; end
      2'b11: begin byte_start = 8'b1111_1111; last_cnt = 6'd7;  end
    endcase
  end

  // Bit-level lane start/MSB masks and per-byte add enables
  always_comb begin
    logic en_cur;
    start_bits = '0;
    byte_en    = '0;
    en_cur     = 1'b0;
    for (int j = 0; j < NumBytes; j++) begin
      start_bits[8*j] = byte_start[j];
      if (byte_start[j]) en_cur = mplier_q[8*j];
      byte_en[j] = en_cur;
    end
    msb_bits = {1'b1, start_bits[WIDTH-1:1]};
  end

  // Lane-segmented add: carry into the lowest byte of every lane is forced to zero
  always_comb begin
    logic       carry;
    logic [8:0] part;
    acc_sum = '0;
    carry   = 1'b0;
    part    = '0;
    for (int j = 0; j < NumBytes; j++) begin
      part = {1'b0, acc_q[8*j +: 8]}
           + {1'b0, (byte_en[j] ? mcand_q[8*j +: 8] : 8'h00)}
           + {8'h00, (byte_start[j] ? 1'b0 : carry)};
      acc_sum[8*j +: 8] = part[7:0];
      carry             = part[8];
    end
  end

  // Per-lane shifts: nothing crosses a lane boundary
  assign mcand_shl  = (mcand_q << 1) & ~start_bits;
  assign mplier_shr = (mplier_q >> 1) & ~msb_bits;

`ifdef VBW_MUL_EARLY_EXIT_EN
  assign run_last = (cnt_q == last_cnt) || (mplier_shr == '0);
`else
  assign run_last = (cnt_q == last_cnt);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StRun;
      StRun:   if (run_last)  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Datapath registers: load on accept, iterate in RUN, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mode_q   <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      mode_q   <= control;
      cnt_q    <= '0;
    end else if (state_q == StRun) begin
      mcand_q  <= mcand_shl;
      mplier_q <= mplier_shr;
      acc_q    <= acc_sum;
      cnt_q    <= cnt_q + 6'd1;
    end
  end

  // Outputs decoded from state; s always reflects the accumulator
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StRun);
    out_valid = (state_q == StDone);
    s         = acc_q;
  end

endmodule

// File: tb/tb_vbw_mul_seq.sv
// Scoreboard bench for vbw_mul_seq: the driver pushes expected results from a per-lane
// arithmetic model, a monitor pops and compares whenever out_valid rises.
module tb_vbw_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [1:0]  control = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] s;
  logic        busy;

  vbw_mul_seq #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rst_n && in_valid && in_ready) accept_cyc <= cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Per-lane truncated product with plain arithmetic; latency from the multiplier bits
  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                          input logic [1:0] m, output int lat);
    int          lw;
    int          hi;
    logic [63:0] mask, xl, yl, res;
    lw   = 64 >> m;
    mask = (lw == 64) ? {64{1'b1}} : ((64'd1 << lw) - 64'd1);
    res  = '0;
    hi   = 0;
    for (int i = 0; i < 64 / lw; i++) begin
      xl  = (x >> (i * lw)) & mask;
      yl  = (y >> (i * lw)) & mask;
      res = res | (((xl * yl) & mask) << (i * lw));
      for (int j = 0; j < lw; j++) if (yl[j] && (j + 1) > hi) hi = j + 1;
    end
`ifdef VBW_MUL_EARLY_EXIT_EN
    lat = (hi == 0) ? 1 : hi;
`else
    lat = lw;
`endif
    return res;
  endfunction

  // Monitor: compare on every rising out_valid
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov <= 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got %h, want no output", s);
        end else begin
          mon_e = sb.pop_front();
          check("result", s, mon_e.s);
          check("latency", 64'(cyc - accept_cyc - 1), 64'(mon_e.lat));
          check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
          check("busy_in_done", {63'd0, busy}, 64'd0);
        end
      end
      prev_ov <= out_valid;
    end
  end

  // Present one operation at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic [1:0] m);
    exp_t e;
    int   t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got 0, want 1");
    end
    e.s = ref_mul(x, y, m, e.lat);
    sb.push_back(e);
    a        = x;
    b        = y;
    control  = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    control  = 2'($urandom);
    check("in_ready_after_accept", {63'd0, in_ready}, 64'd0);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  // Bounded wait until out_valid is seen at a negedge
  task automatic wait_done();
    int t = 0;
    while (!out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL out_valid_timeout: got 0, want 1");
    end
  endtask

  // Release the result and verify it is consumed on that edge
  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    check("released", {63'd0, out_valid}, 64'd0);
    check("in_ready_after_release", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic [1:0] m);
    issue(x, y, m);
    wait_done();
    release_result();
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [1:0]  rm;

    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_s", s, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(64'd3, 64'd5, 2'b00);
    run_op({32'hFFFF_FFFF, 32'd2}, {32'd2, 32'd3}, 2'b01);
    run_op(64'h0202_0202_0202_FF10, 64'h0303_0303_0303_FF10, 2'b11);
    run_op(64'd9, 64'd1, 2'b00);
    run_op(64'd12345, 64'd0, 2'b00);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10);

    // Backpressure: result held, in_valid ignored while stalled
    out_ready = 1'b0;
    issue(64'h0004_0004_0004_0004, 64'h0004_0004_0004_0004, 2'b10);
    wait_done();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_s", s, 64'h0010_0010_0010_0010);
    end
    in_valid = 1'b0;
    release_result();

    // Reset during RUN
    issue({$urandom, $urandom} | 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 2'b00);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrun_busy", {63'd0, busy}, 64'd0);
    check("midrun_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrun_s", s, 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(64'd7, 64'd6, 2'b00);

    // Randomized operations with random stalls
    for (int n = 0; n < 16; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 63);
      rm = 2'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      issue(ra, rb, rm);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
